// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer for the HH:MM:SS counter chain: mode/up/down buttons to per-field strobes.
// Build option: define CLK_SET_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
module clock_set_ctrl #(
  parameter int unsigned CNT_W         = 14,
  parameter int unsigned HOLD_TICKS    = 500,
  parameter int unsigned REPEAT_TICKS  = 100,
  parameter int unsigned TIMEOUT_TICKS = 10000,
  parameter int unsigned BLINK_TICKS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       run_en,
  output logic       up_h,
  output logic       down_h,
  output logic       up_m,
  output logic       down_m,
  output logic       up_s,
  output logic       down_s,
  output logic [1:0] sel,
  output logic       blink,
  output logic       set_active
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (HOLD_TICKS == 0 || REPEAT_TICKS == 0 || TIMEOUT_TICKS == 0 || BLINK_TICKS == 0 ||
      64'(HOLD_TICKS) >= CNT_LIMIT || 64'(REPEAT_TICKS) >= CNT_LIMIT ||
      64'(TIMEOUT_TICKS) >= CNT_LIMIT || 64'(BLINK_TICKS) >= CNT_LIMIT) begin : g_param_check
    $error("clock_set_ctrl: every *_TICKS value must be nonzero and below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, up_q, down_q;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             fire_up, fire_dn;
  logic             run_en_d, set_active_d, blink_d;
  logic [1:0]       sel_d;
  logic             up_h_d, down_h_d, up_m_d, down_m_d, up_s_d, down_s_d;
`ifdef CLK_SET_AUTOREPEAT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             armed_q, armed_d;
  logic             rep_q, rep_d;
`endif

  logic mode_rise, up_rise, down_rise;
  assign mode_rise = btn_mode & ~mode_q;
  assign up_rise   = btn_up   & ~up_q;
  assign down_rise = btn_down & ~down_q;

  // State, counters, edge history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      mode_q     <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      idle_q     <= '0;
      blk_q      <= '0;
      run_en     <= 1'b1;
      set_active <= 1'b0;
      sel        <= 2'd0;
      blink      <= 1'b0;
      up_h       <= 1'b0;
      down_h     <= 1'b0;
      up_m       <= 1'b0;
      down_m     <= 1'b0;
      up_s       <= 1'b0;
      down_s     <= 1'b0;
`ifdef CLK_SET_AUTOREPEAT_EN
      hold_q     <= '0;
      armed_q    <= 1'b0;
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= btn_mode;
      up_q       <= btn_up;
      down_q     <= btn_down;
      idle_q     <= idle_d;
      blk_q      <= blk_d;
      run_en     <= run_en_d;
      set_active <= set_active_d;
      sel        <= sel_d;
      blink      <= blink_d;
      up_h       <= up_h_d;
      down_h     <= down_h_d;
      up_m       <= up_m_d;
      down_m     <= down_m_d;
      up_s       <= up_s_d;
      down_s     <= down_s_d;
`ifdef CLK_SET_AUTOREPEAT_EN
      hold_q     <= hold_d;
      armed_q    <= armed_d;
      rep_q      <= rep_d;
`endif
    end
  end

  // Next state, strobe decision, hold and idle counters
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    fire_up = 1'b0;
    fire_dn = 1'b0;
`ifdef CLK_SET_AUTOREPEAT_EN
    hold_d  = hold_q;
    armed_d = armed_q;
    rep_d   = rep_q;
`endif
    if (mode_rise) begin
      // mode wins over any coincident up/down edge
      state_d = state_t'(2'(state_q + 2'd1));
      idle_d  = '0;
`ifdef CLK_SET_AUTOREPEAT_EN
      hold_d  = '0;
      armed_d = 1'b0;
      rep_d   = 1'b0;
`endif
    end else if (state_q == ST_RUN) begin
      idle_d = '0;
`ifdef CLK_SET_AUTOREPEAT_EN
      hold_d  = '0;
      armed_d = 1'b0;
      rep_d   = 1'b0;
`endif
    end else begin
      fire_up = up_rise & ~btn_down;
      fire_dn = down_rise & ~btn_up;
`ifdef CLK_SET_AUTOREPEAT_EN
      if (!(btn_up ^ btn_down)) begin
        hold_d  = '0;
        armed_d = 1'b0;
        rep_d   = 1'b0;
      end else if (fire_up | fire_dn) begin
        hold_d  = '0;
        armed_d = 1'b1;
        rep_d   = 1'b0;
      end else if (armed_q && tick) begin
        // first strobe after HOLD_TICKS, then every REPEAT_TICKS
        if (hold_q == (rep_q ? CNT_W'(REPEAT_TICKS - 1) : CNT_W'(HOLD_TICKS - 1))) begin
          fire_up = btn_up;
          fire_dn = btn_down;
          hold_d  = '0;
          rep_d   = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
`endif
      if (up_rise | down_rise | fire_up | fire_dn) begin
        idle_d = '0;
      end else if (tick) begin
        if (idle_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
          state_d = ST_RUN;
          idle_d  = '0;
`ifdef CLK_SET_AUTOREPEAT_EN
          hold_d  = '0;
          armed_d = 1'b0;
          rep_d   = 1'b0;
`endif
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
    end
  end

  // Output next values and blink phase
  always_comb begin
    run_en_d     = (state_d == ST_RUN);
    set_active_d = (state_d != ST_RUN);
    sel_d        = 2'(state_d);
    up_h_d       = fire_up & (state_q == ST_SET_H);
    down_h_d     = fire_dn & (state_q == ST_SET_H);
    up_m_d       = fire_up & (state_q == ST_SET_M);
    down_m_d     = fire_dn & (state_q == ST_SET_M);
    up_s_d       = fire_up & (state_q == ST_SET_S);
    down_s_d     = fire_dn & (state_q == ST_SET_S);
    blink_d      = blink;
    blk_d        = blk_q;
    if (state_d == ST_RUN) begin
      blink_d = 1'b0;
      blk_d   = '0;
    end else if ((state_d != state_q) || fire_up || fire_dn) begin
      blink_d = 1'b1;
      blk_d   = '0;
    end else if (tick) begin
      if (blk_q == CNT_W'(BLINK_TICKS - 1)) begin
        blink_d = ~blink;
        blk_d   = '0;
      end else begin
        blk_d = blk_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: a tick-arithmetic reference model predicts outputs and strobes.
module tb_clock_set_ctrl;

  localparam int HOLD = 500;
  localparam int REP  = 100;
  localparam int TMO  = 10000;
  localparam int BLK  = 250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, btn_mode, btn_up, btn_down;
  logic       run_en, up_h, down_h, up_m, down_m, up_s, down_s, blink, set_active;
  logic [1:0] sel;

  clock_set_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .run_en(run_en), .up_h(up_h), .down_h(down_h), .up_m(up_m), .down_m(down_m),
    .up_s(up_s), .down_s(down_s), .sel(sel), .blink(blink), .set_active(set_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dm_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [5:0] v;   // {up_h,down_h,up_m,down_m,up_s,down_s}
  } strb_t;

  strb_t      strb_q[$];
  logic [4:0] exp_q[$];  // {sel, run_en, set_active, blink}

  // reference model state: field index, edge history, tick counts since events
  int m_field, m_held, m_idle, m_bt;
  bit m_pm, m_pu, m_pd, m_armed, m_blink;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_field = 0; m_held = 0; m_idle = 0; m_bt = 0;
    m_pm = 0; m_pu = 0; m_pd = 0; m_armed = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit m, input bit u, input bit d, input bit t);
    bit    me, ue, de, chg;
    int    dir;
    strb_t s;
    me = m && !m_pm;
    ue = u && !m_pu;
    de = d && !m_pd;
    dir = -1;
    chg = 0;
    if (me) begin
      m_field = (m_field + 1) % 4;
      chg = 1;
      m_armed = 0;
    end else if (m_field != 0) begin
      if (u && d) m_armed = 0;
      else if (ue || de) begin
        dir = ue ? 0 : 1;
        m_armed = 1;
        m_held = 0;
      end
`ifdef CLK_SET_AUTOREPEAT_EN
      else if (m_armed && t && (u ^ d)) begin
        m_held++;
        if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REP == 0)) dir = u ? 0 : 1;
      end
      if (!(u ^ d)) m_armed = 0;
`endif
    end
    if (me || ue || de || dir >= 0) m_idle = 0;
    else if (m_field != 0 && t) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_field = 0;
        chg = 1;
        m_armed = 0;
        m_idle = 0;
      end
    end
    if (m_field == 0) begin
      m_blink = 0;
      m_bt = 0;
    end else if (chg || dir >= 0) begin
      m_blink = 1;
      m_bt = 0;
    end else if (t) begin
      m_bt++;
      m_blink = ((m_bt / BLK) % 2) == 0;
    end
    exp_q.push_back({2'(m_field), m_field == 0, m_field != 0, m_blink});
    if (dir >= 0) begin
      s.c = cyc + 1;
      s.v = '0;
      s.v[(3 - m_field) * 2 + (dir == 0 ? 1 : 0)] = 1'b1;
      strb_q.push_back(s);
    end
    m_pm = m; m_pu = u; m_pd = d;
  endtask

  task automatic step(input bit m, input bit u, input bit d, input bit t);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; tick = t;
    model_step(m, u, d, t);
  endtask

  // monitor: pop and compare whenever the DUT presents a strobe; per-cycle status from exp_q
  logic [5:0] mon_sv;
  strb_t      mon_s;
  logic [4:0] mon_e;
  always begin
    @(posedge clk);
    #2;
    mon_sv = {up_h, down_h, up_m, down_m, up_s, down_s};
    while (strb_q.size() > 0 && strb_q[0].c < cyc) begin
      mon_s = strb_q.pop_front();
      check("strobe_missed", 32'(0), 32'(mon_s.v));
    end
    if (mon_sv != 6'd0) begin
      if (down_m) dm_cnt++;
      if (strb_q.size() == 0) check("strobe_unexpected", 32'(mon_sv), 32'(0));
      else begin
        mon_s = strb_q.pop_front();
        check("strobe_vec", 32'(mon_sv), 32'(mon_s.v));
        check("strobe_cycle", 32'(cyc), 32'(mon_s.c));
      end
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sel", 32'(sel), 32'(mon_e[4:3]));
      check("run_en", 32'(run_en), 32'(mon_e[2]));
      check("set_active", 32'(set_active), 32'(mon_e[1]));
      check("blink", 32'(blink), 32'(mon_e[0]));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run_en"}, 32'(run_en), 32'(1));
    check({tag, "_sel"}, 32'(sel), 32'(0));
    check({tag, "_blink"}, 32'(blink), 32'(0));
    check({tag, "_set_active"}, 32'(set_active), 32'(0));
    check({tag, "_strobes"}, 32'({up_h, down_h, up_m, down_m, up_s, down_s}), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cm, cu, cd;
    rst_n = 1'b0; btn_mode = 0; btn_up = 0; btn_down = 0; tick = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // mode cycles RUN->H->M->S->RUN; holding mode does not repeat
    repeat (4) begin
      step(1, 0, 0, 0); step(1, 0, 0, 1); step(0, 0, 0, 0);
    end

    // SET_H: one 3-clk up pulse
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // SET_M: hold down for 800 ticks
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    dm_cnt = 0;
    step(0, 0, 1, 0);
    repeat (800) begin
      step(0, 0, 1, 1); step(0, 0, 1, 0);
    end
    repeat (3) step(0, 0, 0, 0);
`ifdef CLK_SET_AUTOREPEAT_EN
    check("down_m_count", 32'(dm_cnt), 32'(5));
`else
    check("down_m_count", 32'(dm_cnt), 32'(1));
`endif

    // SET_S: simultaneous up+down, then mode+up together
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 0); step(0, 0, 0, 0);
    step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("mode_over_up_sel", 32'(sel), 32'(0));

    // SET_H then idle until timeout
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    repeat (TMO) begin
      step(0, 0, 0, 1); step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    check("timeout_sel", 32'(sel), 32'(0));
    check("timeout_run_en", 32'(run_en), 32'(1));

    // asynchronous reset in the middle of SET_M
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 1);
    @(posedge clk);
    #3;
    check("preabort_sel", 32'(sel), 32'(2));
    btn_mode = 0; btn_up = 0; btn_down = 0; tick = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // randomized button activity
    cm = 0; cu = 0; cd = 0;
    repeat (20000) begin
      if ($urandom_range(0, 299) == 0) cm = !cm;
      if ($urandom_range(0, 699) == 0) cu = !cu;
      if ($urandom_range(0, 699) == 0) cd = !cd;
      step(cm, cu, cd, 1'($urandom_range(0, 1)));
    end
    repeat (4) step(0, 0, 0, 0);
    @(posedge clk);
    #3;
    check("strobe_queue_empty", 32'(strb_q.size()), 32'(0));
    check("status_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
